// File: rtl/booth_mul_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mul_pkg
// Description : Shared types and constants for the sequential radix-4 Booth
//               multiplier: FSM state encoding, Booth digit encodings, and a
//               helper that derives the iteration count from the operand width.
// Revision    : 1.0 - initial release
// ============================================================================
package mul_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Digit encoding packed as {neg, two, zero}.
    localparam logic [2:0] ZERO = 3'b001;
    localparam logic [2:0] POS1 = 3'b000;
    localparam logic [2:0] POS2 = 3'b010;
    localparam logic [2:0] NEG1 = 3'b100;
    localparam logic [2:0] NEG2 = 3'b110;

    // Operands are extended by two bits, so WIDTH+2 multiplier bits are
    // consumed two at a time: WIDTH/2 + 1 iterations.
    function automatic int calc_iter(input int width);
        return width / 2 + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/booth_mul_seq_if.sv
`default_nettype none
// ============================================================================
// Module      : booth_mul_seq_if
// Description : Request/result bundle of the Booth multiplier.
//               master : drives start, is_signed, a, b; receives busy, done,
//                        hi, lo (and early when BOOTH_EARLY_EXIT_EN is defined)
//               slave  : the multiplier side of the same signals
// Macro       : BOOTH_EARLY_EXIT_EN adds the 'early' result flag.
// Revision    : 1.0 - initial release
// ============================================================================
interface booth_mul_seq_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic             is_signed;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
`ifdef BOOTH_EARLY_EXIT_EN
    logic             early;

    modport master (output start, is_signed, a, b,
                    input  busy, done, hi, lo, early);
    modport slave  (input  start, is_signed, a, b,
                    output busy, done, hi, lo, early);
`else
    modport master (output start, is_signed, a, b,
                    input  busy, done, hi, lo);
    modport slave  (input  start, is_signed, a, b,
                    output busy, done, hi, lo);
`endif
endinterface
`default_nettype wire

// File: rtl/booth_mul_seq_digit_enc.sv
`default_nettype none
// ============================================================================
// Module      : booth_digit_enc
// Description : Combinational radix-4 Booth recoder. Maps a 3-bit multiplier
//               window {b[2k+1], b[2k], b[2k-1]} to partial-product selects.
//               window : 3-bit multiplier window
//               neg    : negate the selected multiple
//               two    : select 2M instead of M
//               zero   : digit is 0, partial product suppressed
// Revision    : 1.0 - initial release
// ============================================================================
module booth_digit_enc
    import mul_pkg::*;
(
    input  logic [2:0] window,
    output logic       neg,
    output logic       two,
    output logic       zero
);

    logic [2:0] digit;

    always_comb begin
        digit = ZERO;
        case (window)
            3'b000:  digit = ZERO;
            3'b001:  digit = POS1;
            3'b010:  digit = POS1;
            3'b011:  digit = POS2;
            3'b100:  digit = NEG2;
            3'b101:  digit = NEG1;
            3'b110:  digit = NEG1;
            3'b111:  digit = ZERO;
            default: digit = ZERO;
        endcase
    end

    assign {neg, two, zero} = digit;

endmodule
`default_nettype wire

// File: rtl/booth_mul_seq.sv
`default_nettype none
// ============================================================================
// Module      : booth_mul_seq
// Description : Sequential radix-4 Booth multiplier, one digit per cycle.
//               Produces the full 2*WIDTH-bit signed or unsigned product.
//               clk   : rising-edge clock
//               rst_n : asynchronous active-low reset
//               bus   : booth_mul_seq_if.slave (start/is_signed/a/b in,
//                       busy/done/hi/lo[/early] out)
// Macro       : BOOTH_EARLY_EXIT_EN - finish as soon as the remaining Booth
//               digits are all zero, and flag it on 'early'.
// Revision    : 1.0 - initial release
// ============================================================================
module booth_mul_seq
    import mul_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    booth_mul_seq_if.slave  bus
);

    localparam int ITER  = calc_iter(WIDTH);
    localparam int XW    = WIDTH + 2;        // extended operand width
    localparam int ACC_W = 2 * WIDTH + 4;    // accumulator width
    localparam int CNT_W = $clog2(ITER);

    generate
        if ((WIDTH % 2) != 0 || WIDTH < 4) begin : g_width_check
            $error("booth_mul_seq: WIDTH must be even and at least 4");
        end
    endgenerate

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [ACC_W-1:0]   acc;
    logic [ACC_W-1:0]   mcand;   // M * 4^k, pre-shifted each iteration
    logic [XW:0]        mplr;    // {b', b'[-1]=0}, shifted right by 2 per iteration
    logic               busy;
    logic               done;
    logic [WIDTH-1:0]   hi;
    logic [WIDTH-1:0]   lo;

    logic               dig_neg;
    logic               dig_two;
    logic               dig_zero;
    logic [ACC_W-1:0]   sel_mult;
    logic [ACC_W-1:0]   addend;
    logic [ACC_W-1:0]   acc_next;
    logic               last_iter;
    logic [XW-1:0]      ext_a;
    logic [XW-1:0]      ext_b;

    booth_digit_enc u_enc (
        .window (mplr[2:0]),
        .neg    (dig_neg),
        .two    (dig_two),
        .zero   (dig_zero)
    );

    assign ext_a = {{2{bus.is_signed & bus.a[WIDTH-1]}}, bus.a};
    assign ext_b = {{2{bus.is_signed & bus.b[WIDTH-1]}}, bus.b};

    always_comb begin
        sel_mult = dig_two ? {mcand[ACC_W-2:0], 1'b0} : mcand;
        addend   = '0;
        if (!dig_zero) begin
            addend = dig_neg ? (~sel_mult + ACC_W'(1)) : sel_mult;
        end
        acc_next = acc + addend;
    end

`ifdef BOOTH_EARLY_EXIT_EN
    logic early;
    logic exit_ok;

    // When every unconsumed multiplier bit (including the current window's
    // low bit) equals the sign, all later windows decode to 000/111 = 0.
    assign exit_ok   = (&mplr) | ~(|mplr);
    assign last_iter = (cnt == CNT_W'(ITER - 1)) | exit_ok;
    assign bus.early = early;
`else
    assign last_iter = (cnt == CNT_W'(ITER - 1));
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            acc   <= '0;
            mcand <= '0;
            mplr  <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            hi    <= '0;
            lo    <= '0;
`ifdef BOOTH_EARLY_EXIT_EN
            early <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
`ifdef BOOTH_EARLY_EXIT_EN
            early <= 1'b0;
`endif
            case (state)
                // DONE accepts a new request exactly like IDLE, which gives
                // back-to-back operation without a bubble.
                IDLE, DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                    if (bus.start) begin
                        state <= RUN;
                        busy  <= 1'b1;
                        cnt   <= '0;
                        acc   <= '0;
                        mcand <= {{(ACC_W - XW){ext_a[XW-1]}}, ext_a};
                        mplr  <= {ext_b, 1'b0};
                    end
                end
                RUN: begin
                    acc   <= acc_next;
                    mcand <= {mcand[ACC_W-3:0], 2'b00};
                    mplr  <= {{2{mplr[XW]}}, mplr[XW:2]};
                    cnt   <= cnt + CNT_W'(1);
                    if (last_iter) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        hi    <= acc_next[2*WIDTH-1:WIDTH];
                        lo    <= acc_next[WIDTH-1:0];
`ifdef BOOTH_EARLY_EXIT_EN
                        early <= (cnt != CNT_W'(ITER - 1));
`endif
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy = busy;
    assign bus.done = done;
    assign bus.hi   = hi;
    assign bus.lo   = lo;

endmodule
`default_nettype wire

// File: tb/tb_booth_mul_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_booth_mul_seq
// Description : Self-checking directed testbench for booth_mul_seq (WIDTH=32).
// Macro       : BOOTH_EARLY_EXIT_EN enables the early-exit scenario.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_booth_mul_seq;

    localparam int W    = 32;
    localparam int ITER = W / 2 + 1;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_fail;

    booth_mul_seq_if #(.WIDTH(W)) bus ();

    booth_mul_seq #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Called at a negedge; returns at the negedge where done is seen.
    task automatic do_mul(input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                          input logic ts, output logic [W-1:0] rhi,
                          output logic [W-1:0] rlo, output int ncyc);
        bus.a         = ta;
        bus.b         = tb_v;
        bus.is_signed = ts;
        bus.start     = 1'b1;
        ncyc          = 0;
        do begin
            @(posedge clk);
            ncyc++;
            @(negedge clk);
            if (ncyc == 1) bus.start = 1'b0;
        end while (!bus.done && ncyc < 100);
        rhi = bus.hi;
        rlo = bus.lo;
    endtask

    task automatic test_reset();
        logic [W-1:0] h, l;
        int n;
        int done_seen;
        n_cmp++;
        if ({bus.busy, bus.done, bus.hi, bus.lo} !== {2'b00, 64'h0}) begin
            n_fail++;
            $display("FAIL reset_state: busy=%b done=%b hi=%h lo=%h, want all 0",
                     bus.busy, bus.done, bus.hi, bus.lo);
        end
        // give hi/lo a nonzero value first
        do_mul(32'd1000, 32'd1000, 1'b0, h, l, n);
        bus.a = 32'd12345; bus.b = 32'd678; bus.is_signed = 1'b0; bus.start = 1'b1;
        @(posedge clk); @(negedge clk); bus.start = 1'b0;
        repeat (4) @(negedge clk);
        n_cmp++;
        if (bus.busy !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_prebusy: busy=%b, want 1", bus.busy);
        end
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({bus.busy, bus.done, bus.hi, bus.lo} !== {2'b00, 64'h0}) begin
            n_fail++;
            $display("FAIL reset_midop: busy=%b done=%b hi=%h lo=%h, want all 0",
                     bus.busy, bus.done, bus.hi, bus.lo);
        end
        @(negedge clk);
        rst_n = 1'b1;
        done_seen = 0;
        repeat (25) begin
            @(negedge clk);
            if (bus.done === 1'b1 || bus.busy === 1'b1) done_seen++;
        end
        n_cmp++;
        if (done_seen != 0) begin
            n_fail++;
            $display("FAIL reset_no_done: %0d cycles with busy/done after reset, want 0",
                     done_seen);
        end
        do_mul(32'd9, 32'd11, 1'b0, h, l, n);
        n_cmp++;
        if ({h, l, n} !== {32'd0, 32'd99, ITER + 1}) begin
            n_fail++;
            $display("FAIL reset_recover: hi=%h lo=%h cyc=%0d, want 0/00000063/%0d",
                     h, l, n, ITER + 1);
        end
    endtask

    task automatic test_signed();
        logic [W-1:0] h, l;
        int n;
        do_mul(-32'sd7, 32'd3, 1'b1, h, l, n);
        n_cmp++;
        if (n !== ITER + 1) begin
            n_fail++;
            $display("FAIL signed_latency: cyc=%0d, want %0d", n, ITER + 1);
        end
        n_cmp++;
        if ({h, l} !== 64'hFFFFFFFF_FFFFFFEB) begin
            n_fail++;
            $display("FAIL signed_m7x3: got %h_%h, want FFFFFFFF_FFFFFFEB", h, l);
        end
    endtask

    task automatic test_extremes();
        logic [W-1:0] h, l;
        int n;
        do_mul(32'h80000000, 32'h80000000, 1'b1, h, l, n);
        n_cmp++;
        if ({h, l} !== 64'h40000000_00000000) begin
            n_fail++;
            $display("FAIL signed_min_sq: got %h_%h, want 40000000_00000000", h, l);
        end
        do_mul(32'h80000000, 32'hFFFFFFFF, 1'b1, h, l, n);
        n_cmp++;
        if ({h, l} !== 64'h00000000_80000000) begin
            n_fail++;
            $display("FAIL signed_min_m1: got %h_%h, want 00000000_80000000", h, l);
        end
        do_mul(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, h, l, n);
        n_cmp++;
        if ({h, l} !== 64'hFFFFFFFE_00000001) begin
            n_fail++;
            $display("FAIL unsigned_ones: got %h_%h, want FFFFFFFE_00000001", h, l);
        end
        do_mul(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, h, l, n);
        n_cmp++;
        if ({h, l} !== 64'h00000000_00000001) begin
            n_fail++;
            $display("FAIL signed_m1_sq: got %h_%h, want 00000000_00000001", h, l);
        end
        do_mul(32'h0, 32'hDEADBEEF, 1'b1, h, l, n);
        n_cmp++;
        if ({h, l} !== 64'h0) begin
            n_fail++;
            $display("FAIL zero_a: got %h_%h, want 0", h, l);
        end
        do_mul(32'hFFFFFFFF, 32'h0, 1'b0, h, l, n);
        n_cmp++;
        if ({h, l} !== 64'h0) begin
            n_fail++;
            $display("FAIL zero_b: got %h_%h, want 0", h, l);
        end
    endtask

    task automatic test_start_held();
        int n;
        bus.a = 32'd5; bus.b = 32'd6; bus.is_signed = 1'b1; bus.start = 1'b1;
        n = 0;
        do begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (n <= 10) begin
                bus.a = $urandom;
                bus.b = $urandom;
            end
            if (n == 5) bus.is_signed = 1'b0;
            if (n == 11) bus.start = 1'b0;
        end while (!bus.done && n < 100);
        n_cmp++;
        if ({bus.hi, bus.lo, n} !== {32'd0, 32'd30, ITER + 1}) begin
            n_fail++;
            $display("FAIL start_held: hi=%h lo=%h cyc=%0d, want 0/0000001e/%0d",
                     bus.hi, bus.lo, n, ITER + 1);
        end
        bus.start = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] h, l;
        int n;
        do_mul(32'd100, 32'd200, 1'b0, h, l, n);
        n_cmp++;
        if ({h, l} !== {32'd0, 32'd20000}) begin
            n_fail++;
            $display("FAIL b2b_first: got %h_%h, want 00000000_00004e20", h, l);
        end
        // still in the DONE cycle: issue the next request right away
        do_mul(32'hFFFFFFFE, 32'd3, 1'b1, h, l, n);
        n_cmp++;
        if ({h, l, n} !== {64'hFFFFFFFF_FFFFFFFA, ITER + 1}) begin
            n_fail++;
            $display("FAIL b2b_second: got %h_%h cyc=%0d, want FFFFFFFF_FFFFFFFA/%0d",
                     h, l, n, ITER + 1);
        end
    endtask

    task automatic test_hold();
        int n;
        int bad;
        repeat (5) @(negedge clk);
        n_cmp++;
        if ({bus.hi, bus.lo} !== 64'hFFFFFFFF_FFFFFFFA) begin
            n_fail++;
            $display("FAIL hold_idle: got %h_%h, want FFFFFFFF_FFFFFFFA", bus.hi, bus.lo);
        end
        bus.a = 32'h12345678; bus.b = 32'h10; bus.is_signed = 1'b0; bus.start = 1'b1;
        n = 0;
        bad = 0;
        do begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (n == 1) bus.start = 1'b0;
            if (!bus.done && {bus.hi, bus.lo} !== 64'hFFFFFFFF_FFFFFFFA) bad++;
        end while (!bus.done && n < 100);
        n_cmp++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL hold_run: %0d cycles with hi/lo changed during RUN, want 0", bad);
        end
        n_cmp++;
        if ({bus.hi, bus.lo} !== 64'h00000001_23456780) begin
            n_fail++;
            $display("FAIL hold_result: got %h_%h, want 00000001_23456780", bus.hi, bus.lo);
        end
        @(negedge clk);
    endtask

    task automatic test_random();
        logic [W-1:0] ra, rb, h, l;
        logic [2*W-1:0] exp_p;
        logic signed [2*W-1:0] sa, sb;
        int n;
        for (int i = 0; i < 200; i++) begin
            ra = $urandom;
            rb = $urandom;
            if (i[0]) begin
                sa = $signed({{W{ra[W-1]}}, ra});
                sb = $signed({{W{rb[W-1]}}, rb});
                exp_p = sa * sb;
            end else begin
                exp_p = {{W{1'b0}}, ra} * {{W{1'b0}}, rb};
            end
            do_mul(ra, rb, i[0], h, l, n);
            n_cmp++;
            if ({h, l} !== exp_p || n !== ITER + 1) begin
                n_fail++;
                $display("FAIL random[%0d]: a=%h b=%h s=%b got %h_%h cyc=%0d, want %h cyc=%0d",
                         i, ra, rb, i[0], h, l, n, exp_p, ITER + 1);
            end
        end
    endtask

`ifdef BOOTH_EARLY_EXIT_EN
    task automatic test_early();
        logic [W-1:0] h, l;
        int n;
        do_mul(32'd123, 32'd1, 1'b0, h, l, n);
        n_cmp++;
        if ({h, l, n, bus.early} !== {32'd0, 32'd123, 32'd3, 1'b1}) begin
            n_fail++;
            $display("FAIL early_b1: got %h_%h cyc=%0d early=%b, want 0/0000007b/3/1",
                     h, l, n, bus.early);
        end
        do_mul(32'd3, 32'h40000000, 1'b1, h, l, n);
        n_cmp++;
        if ({h, l, n, bus.early} !== {32'd0, 32'hC0000000, ITER + 1, 1'b0}) begin
            n_fail++;
            $display("FAIL early_full: got %h_%h cyc=%0d early=%b, want 0/c0000000/%0d/0",
                     h, l, n, bus.early, ITER + 1);
        end
    endtask
`endif

    initial begin
        n_cmp         = 0;
        n_fail        = 0;
        rst_n         = 1'b0;
        bus.start     = 1'b0;
        bus.is_signed = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        repeat (3) @(negedge clk);
        test_reset_pre();
        rst_n = 1'b1;
        @(negedge clk);
        test_reset();
        test_signed();
        test_extremes();
        test_start_held();
        test_back_to_back();
        test_hold();
        test_random();
`ifdef BOOTH_EARLY_EXIT_EN
        test_early();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    // Values while reset is still held from time zero.
    task automatic test_reset_pre();
        n_cmp++;
        if ({bus.busy, bus.done, bus.hi, bus.lo} !== {2'b00, 64'h0}) begin
            n_fail++;
            $display("FAIL reset_held: busy=%b done=%b hi=%h lo=%h, want all 0",
                     bus.busy, bus.done, bus.hi, bus.lo);
        end
    endtask

endmodule
`default_nettype wire
